// File: rtl/blake2_g_sched_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : blake2_g_sched_if                                             |
// | Brief    : Start/ready and G-operation issue handshake of the Blake2      |
// |            G-function scheduler.                                         |
// | Revision : 1.0                                                          |
// +--------------------------------------------------------------------------+
interface blake2_g_sched_if;
    logic       init;
    logic       ready;
    logic       g_valid;
    logic       g_ready;
    logic [3:0] g_a_idx;
    logic [3:0] g_b_idx;
    logic [3:0] g_c_idx;
    logic [3:0] g_d_idx;
    logic [3:0] g_m0_idx;
    logic [3:0] g_m1_idx;
    logic [3:0] round;
    logic       update;

    modport master (
        input  init, g_ready,
        output ready, g_valid, g_a_idx, g_b_idx, g_c_idx, g_d_idx,
               g_m0_idx, g_m1_idx, round, update
    );

    modport slave (
        output init, g_ready,
        input  ready, g_valid, g_a_idx, g_b_idx, g_c_idx, g_d_idx,
               g_m0_idx, g_m1_idx, round, update
    );
endinterface
`default_nettype wire

// File: rtl/blake2_g_sched.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : blake2_g_sched                                                |
// | Brief    : Sequences the 8 G operations per round of Blake2 compression, |
// |            issuing v/m word indices. BLAKE2_G_SCHED_ABORT_EN adds abort.  |
// | Revision : 1.0                                                          |
// +--------------------------------------------------------------------------+
module blake2_g_sched #(
    parameter int NUM_ROUNDS = 12
) (
    input  wire logic           clk,
    input  wire logic           reset_n,
`ifdef BLAKE2_G_SCHED_ABORT_EN
    input  wire logic           abort,
`endif
    blake2_g_sched_if.master    bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2
    } state_t;

    localparam logic [3:0] c_last_round = 4'(NUM_ROUNDS - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_round;
    logic [3:0]  w_round_nxt;
    logic [2:0]  r_g;
    logic [2:0]  w_g_nxt;
    logic        w_abort;
    logic [1:0]  w_k;
    logic        w_diag;
    logic [3:0]  w_sig_row;
    logic [63:0] w_sig_sh;

`ifdef BLAKE2_G_SCHED_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Row i of SIGMA packed with element 0 in the top nibble.
    function automatic logic [63:0] sigma_row(input logic [3:0] r);
        logic [63:0] row;
        case (r)
            4'd0:    row = 64'h0123456789ABCDEF;
            4'd1:    row = 64'hEA489FD61C02B753;
            4'd2:    row = 64'hB8C052FDAE367194;
            4'd3:    row = 64'h7931DCBE265A40F8;
            4'd4:    row = 64'h905724AFE1BC683D;
            4'd5:    row = 64'h2C6A0B834D75FE19;
            4'd6:    row = 64'hC51FED4A0763928B;
            4'd7:    row = 64'hDB7EC13950F4862A;
            4'd8:    row = 64'h6FE9B308C2D714A5;
            4'd9:    row = 64'hA2847615FB9E3CD0;
            default: row = 64'h0123456789ABCDEF;
        endcase
        return row;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_round <= 4'd0;
            r_g     <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_round <= w_round_nxt;
            r_g     <= w_g_nxt;
        end
    end

    // Column/diagonal pattern: lane k, diagonal steps rotate b,c,d by 1,2,3.
    assign w_k       = r_g[1:0];
    assign w_diag    = r_g[2];
    assign w_sig_row = (r_round >= 4'd10) ? (r_round - 4'd10) : r_round;
    assign w_sig_sh  = sigma_row(w_sig_row) << {r_g, 3'b000};

    always_comb begin
        w_state_nxt  = r_state;
        w_round_nxt  = r_round;
        w_g_nxt      = r_g;
        bus.ready    = 1'b0;
        bus.g_valid  = 1'b0;
        bus.update   = 1'b0;
        bus.round    = r_round;
        bus.g_a_idx  = 4'd0;
        bus.g_b_idx  = 4'd0;
        bus.g_c_idx  = 4'd0;
        bus.g_d_idx  = 4'd0;
        bus.g_m0_idx = 4'd0;
        bus.g_m1_idx = 4'd0;

        case (r_state)
            S_IDLE: begin
                bus.ready = 1'b1;
                if (bus.init) begin
                    w_state_nxt = S_ROUND;
                    w_round_nxt = 4'd0;
                    w_g_nxt     = 3'd0;
                end
            end
            S_ROUND: begin
                bus.g_valid  = 1'b1;
                bus.g_a_idx  = {2'b00, w_k};
                bus.g_b_idx  = {2'b01, w_k + {1'b0, w_diag}};
                bus.g_c_idx  = {2'b10, w_k + {w_diag, 1'b0}};
                bus.g_d_idx  = {2'b11, w_k + {w_diag, w_diag}};
                bus.g_m0_idx = w_sig_sh[63:60];
                bus.g_m1_idx = w_sig_sh[59:56];
                if (bus.g_ready) begin
                    if (r_g == 3'd7) begin
                        w_g_nxt = 3'd0;
                        if (r_round == c_last_round) begin
                            w_state_nxt = S_FINAL;
                        end else begin
                            w_round_nxt = r_round + 4'd1;
                        end
                    end else begin
                        w_g_nxt = r_g + 3'd1;
                    end
                end
            end
            S_FINAL: begin
                bus.update  = ~w_abort;
                w_state_nxt = S_IDLE;
                w_round_nxt = 4'd0;
                w_g_nxt     = 3'd0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_round_nxt = 4'd0;
                w_g_nxt     = 3'd0;
            end
        endcase

        if (w_abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_round_nxt = 4'd0;
            w_g_nxt     = 3'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_blake2_g_sched.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_blake2_g_sched                                             |
// | Brief    : Directed self-checking bench for blake2_g_sched (12 rounds).  |
// | Revision : 1.0                                                          |
// +--------------------------------------------------------------------------+
module tb_blake2_g_sched;

    localparam int NUM_ROUNDS = 12;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
`ifdef BLAKE2_G_SCHED_ABORT_EN
    logic abort   = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int iss;
    int cyc;

    int sigma [10][16] = '{
        '{ 0, 1, 2, 3, 4, 5, 6, 7, 8, 9,10,11,12,13,14,15},
        '{14,10, 4, 8, 9,15,13, 6, 1,12, 0, 2,11, 7, 5, 3},
        '{11, 8,12, 0, 5, 2,15,13,10,14, 3, 6, 7, 1, 9, 4},
        '{ 7, 9, 3, 1,13,12,11,14, 2, 6, 5,10, 4, 0,15, 8},
        '{ 9, 0, 5, 7, 2, 4,10,15,14, 1,11,12, 6, 8, 3,13},
        '{ 2,12, 6,10, 0,11, 8, 3, 4,13, 7, 5,15,14, 1, 9},
        '{12, 5, 1,15,14,13, 4,10, 0, 7, 6, 3, 9, 2, 8,11},
        '{13,11, 7,14,12, 1, 3, 9, 5, 0,15, 4, 8, 6, 2,10},
        '{ 6,15,14, 9,11, 3, 0, 8,12, 2,13, 7, 1, 4,10, 5},
        '{10, 2, 8, 4, 7, 6, 1, 5,15,11, 9,14, 3,12,13, 0}};
    int ea [8] = '{ 0, 1, 2, 3, 0, 1, 2, 3};
    int eb [8] = '{ 4, 5, 6, 7, 5, 6, 7, 4};
    int ec [8] = '{ 8, 9,10,11,10,11, 8, 9};
    int ed [8] = '{12,13,14,15,15,12,13,14};

    always #5 clk = ~clk;

    blake2_g_sched_if bus ();

    blake2_g_sched #(.NUM_ROUNDS(NUM_ROUNDS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
`ifdef BLAKE2_G_SCHED_ABORT_EN
        .abort   (abort),
`endif
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"},   bus.ready,   1);
        check({tag, "_g_valid"}, bus.g_valid, 0);
        check({tag, "_update"},  bus.update,  0);
        check({tag, "_round"},   bus.round,   0);
        check({tag, "_idx"}, {bus.g_a_idx, bus.g_b_idx, bus.g_c_idx, bus.g_d_idx,
                              bus.g_m0_idx, bus.g_m1_idx}, 0);
    endtask

    function automatic int abcd(input int a, input int b, input int c, input int d);
        return (a << 12) | (b << 8) | (c << 4) | d;
    endfunction

    // Starts a run, follows it to the update cycle and then into IDLE.
    task automatic run_checked(input bit hold_init, input int stall_r, input int stall_g,
                               input int stall_len, output int issues, output int cycles);
        int er, eg, stalled;
        bit done;
        er = 0; eg = 0; stalled = 0; issues = 0; cycles = 0; done = 0;
        bus.init    = 1'b1;
        bus.g_ready = 1'b1;
        tick;
        if (!hold_init) bus.init = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            cycles++;
            if (bus.update === 1'b1) begin
                done = 1;
            end else begin
                check("g_valid", bus.g_valid, 1);
                check("ready_busy", bus.ready, 0);
                check("round", bus.round, er);
                check("abcd", {bus.g_a_idx, bus.g_b_idx, bus.g_c_idx, bus.g_d_idx},
                      abcd(ea[eg], eb[eg], ec[eg], ed[eg]));
                check("m0", bus.g_m0_idx, sigma[er % 10][2*eg]);
                check("m1", bus.g_m1_idx, sigma[er % 10][2*eg+1]);
                if (er == 1 && eg == 0) begin
                    check("r1g0_abcd", {bus.g_a_idx, bus.g_b_idx, bus.g_c_idx, bus.g_d_idx}, 16'h048C);
                    check("r1g0_m", {bus.g_m0_idx, bus.g_m1_idx}, {4'd14, 4'd10});
                end
                if (er == 1 && eg == 4) begin
                    check("r1g4_abcd", {bus.g_a_idx, bus.g_b_idx, bus.g_c_idx, bus.g_d_idx}, 16'h05AF);
                    check("r1g4_m", {bus.g_m0_idx, bus.g_m1_idx}, {4'd1, 4'd12});
                end
                if (er == 10 && eg == 0)
                    check("r10g0_m", {bus.g_m0_idx, bus.g_m1_idx}, {4'd0, 4'd1});
                if (er == 11 && eg == 0)
                    check("r11g0_m", {bus.g_m0_idx, bus.g_m1_idx}, {4'd14, 4'd10});
                if (er == 3 && eg == 6) begin
                    check("r3g6_abcd", {bus.g_a_idx, bus.g_b_idx, bus.g_c_idx, bus.g_d_idx}, 16'h278D);
                    check("r3g6_m", {bus.g_m0_idx, bus.g_m1_idx}, {4'd4, 4'd0});
                end
                if (er == stall_r && eg == stall_g && stalled < stall_len) begin
                    bus.g_ready = 1'b0;
                    stalled++;
                end else begin
                    bus.g_ready = 1'b1;
                    issues++;
                    if (eg == 7) begin
                        eg = 0;
                        er++;
                    end else begin
                        eg++;
                    end
                end
                tick;
            end
        end
        bus.g_ready = 1'b1;
        check("update_seen", done, 1);
        check("final_g_valid", bus.g_valid, 0);
        check("final_ready", bus.ready, 0);
        tick;
        check("update_one_cycle", bus.update, 0);
        check("ready_after_run", bus.ready, 1);
    endtask

    initial begin
        bus.init    = 1'b0;
        bus.g_ready = 1'b1;
        reset_n     = 1'b0;
        tick;
        tick;
        check_idle("reset");
        reset_n = 1'b1;
        tick;
        check_idle("idle");

        // Plain run: 96 issues, update 97 cycles after acceptance
        run_checked(0, -1, -1, 0, iss, cyc);
        check("run1_issues", iss, 8 * NUM_ROUNDS);
        check("run1_cycles", cyc, 8 * NUM_ROUNDS + 1);
        check_idle("run1_done");

        // Five stall cycles at round 3, g=6
        run_checked(0, 3, 6, 5, iss, cyc);
        check("stall_issues", iss, 8 * NUM_ROUNDS);
        check("stall_cycles", cyc, 8 * NUM_ROUNDS + 6);

        // init held high throughout: one update per run, restart only from IDLE
        run_checked(1, -1, -1, 0, iss, cyc);
        check("hold_issues", iss, 8 * NUM_ROUNDS);
        check("hold_cycles", cyc, 8 * NUM_ROUNDS + 1);
        tick;
        check("restart_valid", bus.g_valid, 1);
        check("restart_round", bus.round, 0);
        check("restart_abcd", {bus.g_a_idx, bus.g_b_idx, bus.g_c_idx, bus.g_d_idx}, 16'h048C);
        repeat (40) tick;
        check("mid_round5", bus.round, 5);
        check("mid_valid", bus.g_valid, 1);
        bus.init = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_idle("async_reset");
        repeat (4) begin
            tick;
            check("reset_no_update", bus.update, 0);
        end
        reset_n = 1'b1;
        tick;
        check_idle("post_reset");

        run_checked(0, -1, -1, 0, iss, cyc);
        check("run4_issues", iss, 8 * NUM_ROUNDS);
        check("run4_cycles", cyc, 8 * NUM_ROUNDS + 1);

`ifdef BLAKE2_G_SCHED_ABORT_EN
        abort = 1'b1;
        tick;
        check_idle("abort_in_idle");
        abort = 1'b0;
        bus.init = 1'b1;
        tick;
        bus.init = 1'b0;
        repeat (19) tick;
        check("abort_at_round", bus.round, 2);
        check("abort_at_abcd", {bus.g_a_idx, bus.g_b_idx, bus.g_c_idx, bus.g_d_idx}, 16'h37BF);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check_idle("aborted");
        tick;
        check_idle("aborted_hold");
        run_checked(0, -1, -1, 0, iss, cyc);
        check("post_abort_issues", iss, 8 * NUM_ROUNDS);
        check("post_abort_cycles", cyc, 8 * NUM_ROUNDS + 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
